vga_scanout: RTL and testbench
==============================

# vga_scanout

Pixel-clock scanout engine that drives the framebuffer's read port and the VGA pins. Generates 640x480@60 (parameterisable) raster counters, presents the current pixel coordinate as `h_addr`/`v_addr` to the framebuffer, takes the returned 12-bit `vga_data` and emits gated RGB plus sync. Sits between the framebuffer read side and the board VGA connector; also exports vblank status and a frame counter for CPU polling.

## Interface

- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)

- `clock` in 1 pixel clock (25 MHz nominal); sole clock
- `reset` in 1 synchronous, active-high
- `vga_data` in 12 framebuffer pixel {R[3:0],G[3:0],B[3:0]} for the addressed pixel
- `h_addr` out 10 pixel column to framebuffer; 0 outside active region
- `v_addr` out 10 pixel row to framebuffer; 0 outside active region
- `hsync` out 1 horizontal sync, active-low
- `vsync` out 1 vertical sync, active-low
- `valid` out 1 high while RGB carries a visible pixel
- `vga_r`, `vga_g`, `vga_b` out 4 each colour outputs; 0 when `valid` low
- `vblank` out 1 high while `v_cnt >= V_ACTIVE`
- `frame_start` out 1 one-cycle pulse at `h_cnt==0 && v_cnt==0`
- `frame_cnt` out 16 completed-frame count

## Operation

- Internal registers `h_cnt` (0..H_TOTAL-1, H_TOTAL=800) and `v_cnt` (0..V_TOTAL-1, V_TOTAL=525); both 10 bits.
- Each cycle `h_cnt` increments; at `H_TOTAL-1` wraps to 0 and `v_cnt` increments; at `v_cnt==V_TOTAL-1` with `h_cnt==H_TOTAL-1` both wrap to 0.
- Horizontal order: active [0,639], FP [640,655], sync [656,751], BP [752,799]. Vertical: active [0,479], FP [480,489], sync [490,491], BP [492,524].
- Active = `h_cnt<H_ACTIVE && v_cnt<V_ACTIVE`. `h_addr=h_cnt`, `v_addr=v_cnt` when active, else 0 (combinational from counters).
- `hsync` low iff `h_cnt` in sync range; `vsync` low iff `v_cnt` in sync range (decoded, then optionally delayed — see Configuration).
- RGB = `vga_data` split as R=[11:8], G=[7:4], B=[3:0] when `valid`, else 0.
- `frame_cnt` increments on the final cycle of each frame (`h_cnt==799 && v_cnt==524`); wraps 0xFFFF -> 0x0000.
- Reset held: counters 0, `frame_cnt` 0, `valid` 0, `hsync`/`vsync` 1, RGB 0, `h_addr`/`v_addr` 0, `frame_start` 0, `vblank` 0 — all outputs forced to these idle values while `reset` high.
- Reset mid-frame: cycle after deassertion is `h_cnt=0,v_cnt=0`; `frame_start` pulses then; no partial-line completion; `frame_cnt` restarts at 0.

## Timing

- Counters advance on every rising `clock` edge; no stall input.
- Without pipe mode: `valid`, `hsync`, `vsync` are same-cycle decode of counters; `vga_data` must be valid combinationally in the cycle `h_addr`/`v_addr` present (async-read framebuffer).
- With pipe mode: `valid`, `hsync`, `vsync` pass through one register stage; `vga_data` sampled one cycle after its address (1-cycle synchronous-read BRAM). RGB gating uses the delayed `valid`. `h_addr`/`v_addr`, `vblank`, `frame_start`, `frame_cnt` are never delayed.
- Line period 800 cycles; frame period 420000 cycles.

## Configuration

- `VGA_SCANOUT_PIPE_EN` defined: one-cycle alignment stage on `valid`/`hsync`/`vsync` (reset values 0/1/1) for synchronous-read framebuffer.
- Undefined: no alignment stage; all sync/valid outputs combinational from counters, RGB combinational from `vga_data`.

## Test plan

- Reset 5 cycles, release -> during reset all outputs idle values; first cycle after: `h_addr=0,v_addr=0,valid=1,frame_start=1`, `frame_cnt=0`.
- Run one line with `vga_data=12'hFFF` -> `valid` high exactly 640 cycles, RGB=F/F/F then 0 in blanking; `hsync` low for cycles 656..751 (96 wide), plus one cycle later with pipe enabled.
- Line wrap: at `h_cnt=799,v_cnt=3` -> next cycle `h_addr=0,v_addr=4`; at `v_cnt>=480` `h_addr=v_addr=0`, `vblank=1`.
- Frame wrap: run 420000 cycles -> `vsync` low exactly lines 490–491 (1600 cycles), `frame_cnt` 0->1 on the frame-final edge, `frame_start` pulses once per frame; force `frame_cnt=16'hFFFF` -> wraps to 0.
- Pipe alignment (`VGA_SCANOUT_PIPE_EN`): model 1-cycle BRAM returning `{h_addr[3:0],v_addr[3:0],4'h5}` -> every visible RGB matches the address issued one cycle earlier; no pixel at column 0 lost or column 639 duplicated.
- Assert reset at `h_cnt=300,v_cnt=200` for 1 cycle -> next cycle counters 0,0, `frame_start=1`, `frame_cnt=0`, sync outputs return to 1.

Source files
------------

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA raster scanout engine; VGA_SCANOUT_PIPE_EN adds a sync/valid alignment stage for sync-read framebuffers
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] vga_data,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic        hsync,
    output logic        vsync,
    output logic        valid,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vblank,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    // Sync ranges are [start, end) in counter units.
    localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic line_end;
    logic frame_end;
    logic active;
    logic hsync_raw;
    logic vsync_raw;

    logic valid_pre;
    logic hsync_pre;
    logic vsync_pre;

    // Raster counter next-state: pixel counter wraps into line counter, line counter wraps into frame count.
    always_comb begin
        h_cnt_d     = h_cnt_q + 10'd1;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        line_end    = (h_cnt_q == H_LAST);
        frame_end   = line_end && (v_cnt_q == V_LAST);
        if (line_end) begin
            h_cnt_d = 10'd0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = 10'd0;
            end else begin
                v_cnt_d = v_cnt_q + 10'd1;
            end
        end
        if (frame_end) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Raster counter registers; reset restarts the frame at the origin with a fresh frame count.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt_q     <= 10'd0;
            v_cnt_q     <= 10'd0;
            frame_cnt_q <= 16'd0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Region decode from the live counters; syncs are active-low.
    always_comb begin
        active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hsync_raw = !((h_cnt_q >= H_SYNC_LO) && (h_cnt_q < H_SYNC_HI));
        vsync_raw = !((v_cnt_q >= V_SYNC_LO) && (v_cnt_q < V_SYNC_HI));
    end

`ifdef VGA_SCANOUT_PIPE_EN
    logic valid_q;
    logic hsync_q;
    logic vsync_q;

    // One-cycle alignment so valid/syncs line up with pixel data returned by a synchronous-read framebuffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            valid_q <= active;
            hsync_q <= hsync_raw;
            vsync_q <= vsync_raw;
        end
    end

    assign valid_pre = valid_q;
    assign hsync_pre = hsync_q;
    assign vsync_pre = vsync_q;
`else
    assign valid_pre = active;
    assign hsync_pre = hsync_raw;
    assign vsync_pre = vsync_raw;
`endif

    // Output stage: idle values while reset is held, otherwise addresses, status and gated colour.
    always_comb begin
        h_addr      = 10'd0;
        v_addr      = 10'd0;
        hsync       = 1'b1;
        vsync       = 1'b1;
        valid       = 1'b0;
        vga_r       = 4'd0;
        vga_g       = 4'd0;
        vga_b       = 4'd0;
        vblank      = 1'b0;
        frame_start = 1'b0;
        frame_cnt   = 16'd0;
        if (!reset) begin
            if (active) begin
                h_addr = h_cnt_q;
                v_addr = v_cnt_q;
            end
            hsync       = hsync_pre;
            vsync       = vsync_pre;
            valid       = valid_pre;
            vblank      = (v_cnt_q >= V_ACT);
            frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
            frame_cnt   = frame_cnt_q;
            if (valid_pre) begin
                vga_r = vga_data[11:8];
                vga_g = vga_data[7:4];
                vga_b = vga_data[3:0];
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - self-checking bench for vga_scanout on a reduced raster
module tb_vga_scanout;

    localparam int HA = 16;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 4;
    localparam int VA = 8;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
`ifdef VGA_SCANOUT_PIPE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] vga_data;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic        hsync;
    logic        vsync;
    logic        valid;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vblank;
    logic        frame_start;
    logic [15:0] frame_cnt;

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .vga_data(vga_data),
        .h_addr(h_addr),
        .v_addr(v_addr),
        .hsync(hsync),
        .vsync(vsync),
        .valid(valid),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .vblank(vblank),
        .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    always #5 clock = ~clock;

    // Framebuffer model: pixel value encodes its own address.
`ifdef VGA_SCANOUT_PIPE_EN
    always @(posedge clock) vga_data <= {h_addr[3:0], v_addr[3:0], 4'h5};
`else
    always_comb vga_data = {h_addr[3:0], v_addr[3:0], 4'h5};
`endif

    // Reference raster position and frame count.
    int          mh = 0;
    int          mv = 0;
    logic [15:0] mf = 16'd0;

    always @(posedge clock) begin
        if (reset) begin
            mh <= 0;
            mv <= 0;
            mf <= 16'd0;
        end else if (mh == HT - 1) begin
            mh <= 0;
            if (mv == VT - 1) begin
                mv <= 0;
                mf <= mf + 16'd1;
            end else begin
                mv <= mv + 1;
            end
        end else begin
            mh <= mh + 1;
        end
    end

    typedef struct packed {
        logic        valid;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } sb_t;

    sb_t q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic sb_check();
        sb_t         e;
        sb_t         p;
        logic        act;
        logic [9:0]  eh;
        logic [9:0]  ev;
        logic        evb;
        logic        efs;
        logic [15:0] efc;
        act     = !reset && (mh < HA) && (mv < VA);
        e.valid = act;
        e.hs    = reset || !((mh >= HA + HF) && (mh < HA + HF + HS));
        e.vs    = reset || !((mv >= VA + VF) && (mv < VA + VF + VS));
        e.rgb   = act ? {4'(mh), 4'(mv), 4'h5} : 12'h0;
        q.push_back(e);
        if (q.size() > LAT) begin
            p = q.pop_front();
            if (reset) p = {1'b0, 1'b1, 1'b1, 12'h0};
            eh  = act ? 10'(mh) : 10'd0;
            ev  = act ? 10'(mv) : 10'd0;
            evb = !reset && (mv >= VA);
            efs = !reset && (mh == 0) && (mv == 0);
            efc = reset ? 16'd0 : mf;
            n_vec++;
            if ({valid, hsync, vsync, vga_r, vga_g, vga_b, h_addr, v_addr, vblank, frame_start, frame_cnt}
                !== {p, eh, ev, evb, efs, efc}) begin
                n_err++;
                $display("FAIL scoreboard h=%0d v=%0d got val=%b hs=%b vs=%b rgb=%h ha=%0d va=%0d vb=%b fs=%b fc=%0d expected val=%b hs=%b vs=%b rgb=%h ha=%0d va=%0d vb=%b fs=%b fc=%0d",
                         mh, mv, valid, hsync, vsync, {vga_r, vga_g, vga_b}, h_addr, v_addr, vblank, frame_start, frame_cnt,
                         p.valid, p.hs, p.vs, p.rgb, eh, ev, evb, efs, efc);
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        sb_check();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        int          t;
        logic [9:0]  ha;
        logic [9:0]  va;
        logic        vb;
        logic        fs;
        logic [15:0] fc;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int t;
        int cv, l0, chs, cvs, cfs;

        tbl[0]  = '{0,   10'd0,  10'd0, 1'b0, 1'b1, 16'd0};
        tbl[1]  = '{15,  10'd15, 10'd0, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{16,  10'd0,  10'd0, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{29,  10'd0,  10'd0, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{119, 10'd0,  10'd0, 1'b0, 1'b0, 16'd0};
        tbl[5]  = '{120, 10'd0,  10'd4, 1'b0, 1'b0, 16'd0};
        tbl[6]  = '{125, 10'd5,  10'd4, 1'b0, 1'b0, 16'd0};
        tbl[7]  = '{240, 10'd0,  10'd0, 1'b1, 1'b0, 16'd0};
        tbl[8]  = '{449, 10'd0,  10'd0, 1'b1, 1'b0, 16'd0};
        tbl[9]  = '{450, 10'd0,  10'd0, 1'b0, 1'b1, 16'd1};
        tbl[10] = '{675, 10'd15, 10'd7, 1'b0, 1'b0, 16'd1};
        tbl[11] = '{900, 10'd0,  10'd0, 1'b0, 1'b1, 16'd2};

        reset = 1'b1;
        repeat (5) tick();
        chk("reset_idle",
            {h_addr, v_addr, valid, hsync, vsync, vga_r, vga_g, vga_b, vblank, frame_start, frame_cnt},
            {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'd0, 1'b0, 1'b0, 16'd0});
        reset = 1'b0;
        #1;

        t = 0;
        for (int i = 0; i < 12; i++) begin
            while (t < tbl[i].t) begin
                tick();
                t++;
            end
            chk($sformatf("vec%0d_t%0d", i, tbl[i].t),
                {h_addr, v_addr, vblank, frame_start, frame_cnt},
                {tbl[i].ha, tbl[i].va, tbl[i].vb, tbl[i].fs, tbl[i].fc});
        end

        // One full frame of pulse/width counts starting at a frame boundary.
        cv = 0; l0 = 0; chs = 0; cvs = 0; cfs = 0;
        for (int k = 0; k < HT * VT; k++) begin
            if (valid) cv++;
            if (valid && k < HT) l0++;
            if (!hsync) chs++;
            if (!vsync) cvs++;
            if (frame_start) cfs++;
            tick();
            t++;
        end
        chk("frame_valid_cycles", 64'(cv), 64'(HA * VA));
        chk("line0_valid_cycles", 64'(l0), 64'(HA));
        chk("frame_hsync_low", 64'(chs), 64'(HS * VT));
        chk("frame_vsync_low", 64'(cvs), 64'(VS * HT));
        chk("frame_start_pulses", 64'(cfs), 64'd1);

        // Mid-frame reset for a single cycle.
        while (t < 3 * HT * VT + 5 * HT + 10) begin
            tick();
            t++;
        end
        chk("pre_reset_pos", {h_addr, v_addr, frame_cnt}, {10'd10, 10'd5, 16'd3});
        reset = 1'b1;
        #1;
        chk("midreset_idle",
            {h_addr, v_addr, valid, hsync, vsync, vga_r, vga_g, vga_b, vblank, frame_start, frame_cnt},
            {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'd0, 1'b0, 1'b0, 16'd0});
        tick();
        reset = 1'b0;
        #1;
        chk("post_reset_origin",
            {h_addr, v_addr, frame_start, frame_cnt, hsync, vsync},
            {10'd0, 10'd0, 1'b1, 16'd0, 1'b1, 1'b1});
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
